// File: rtl/booth_mult_scheduler.sv
// Job front-end for the sequential Booth multiplier core.
// Buffers operand pairs in a small FIFO. Issues one job at a time to the core.
// Guards each job with a timeout watchdog. Returns tagged products downstream.
module booth_mult_scheduler #(
  parameter int N       = 32,
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 3*N+8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N-1:0]               in_a,
  input  logic [N-1:0]               in_b,
  input  logic [TAG_W-1:0]           in_tag,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [2*N-1:0]             out_c,
  output logic [TAG_W-1:0]           out_tag,
  output logic                       out_err,
  output logic                       mul_load,
  output logic [N-1:0]               mul_a,
  output logic [N-1:0]               mul_b,
  input  logic                       mul_done,
  input  logic [2*N-1:0]             mul_c,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic [7:0]                 err_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_OUT
  } state_t;

  state_t               r_state;

  logic [N-1:0]         r_mem_a   [DEPTH];
  logic [N-1:0]         r_mem_b   [DEPTH];
  logic [TAG_W-1:0]     r_mem_tag [DEPTH];
  logic [AW-1:0]        r_wptr;
  logic [AW-1:0]        r_rptr;
  logic [CW-1:0]        r_count;

  logic [TW-1:0]        r_timer;
  logic [TAG_W-1:0]     r_job_tag;
  logic                 r_out_valid;
  logic [2*N-1:0]       r_out_c;
  logic [TAG_W-1:0]     r_out_tag;
  logic                 r_out_err;
  logic                 r_mul_load;
  logic [N-1:0]         r_mul_a;
  logic [N-1:0]         r_mul_b;
  logic [7:0]           r_err_count;

  logic                 w_push;
  logic                 w_pop;
  logic                 w_not_empty;

  // Full is judged on the registered count alone, so a same-cycle pop does not open a slot.
  assign in_ready    = (r_count != CW'(DEPTH));
  assign w_not_empty = (r_count != '0);
  assign w_push      = in_valid && in_ready;
  assign w_pop       = (r_state == S_IDLE) && w_not_empty;

  assign out_valid  = r_out_valid;
  assign out_c      = r_out_c;
  assign out_tag    = r_out_tag;
  assign out_err    = r_out_err;
  assign mul_load   = r_mul_load;
  assign mul_a      = r_mul_a;
  assign mul_b      = r_mul_b;
  assign fifo_count = r_count;
  assign err_count  = r_err_count;

  // FIFO storage write; contents need no reset because pointers define validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_a[r_wptr]   <= in_a;
      r_mem_b[r_wptr]   <= in_b;
      r_mem_tag[r_wptr] <= in_tag;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Job sequencer: issue, watchdog, result capture and downstream handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_timer     <= '0;
      r_job_tag   <= '0;
      r_out_valid <= 1'b0;
      r_out_c     <= '0;
      r_out_tag   <= '0;
      r_out_err   <= 1'b0;
      r_mul_load  <= 1'b0;
      r_mul_a     <= '0;
      r_mul_b     <= '0;
      r_err_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_not_empty) begin
            r_mul_a    <= r_mem_a[r_rptr];
            r_mul_b    <= r_mem_b[r_rptr];
            r_job_tag  <= r_mem_tag[r_rptr];
            r_mul_load <= 1'b1;
            r_state    <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_mul_load <= 1'b0;
          r_timer    <= '0;
          r_state    <= S_WAIT;
        end
        S_WAIT: begin
          if (mul_done) begin
            r_out_c     <= mul_c;
            r_out_err   <= 1'b0;
            r_out_tag   <= r_job_tag;
            r_out_valid <= 1'b1;
            r_state     <= S_OUT;
          end else if (r_timer == TW'(TIMEOUT - 1)) begin
            r_out_c     <= '0;
            r_out_err   <= 1'b1;
            r_out_tag   <= r_job_tag;
            r_out_valid <= 1'b1;
            if (r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
            r_state     <= S_OUT;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mult_scheduler.sv
// Self-checking bench for booth_mult_scheduler with a behavioural multiplier core.
module tb_booth_mult_scheduler;

  localparam int N       = 32;
  localparam int DEPTH   = 4;
  localparam int TAG_W   = 4;
  localparam int TIMEOUT = 3*N+8;

  logic                   clk;
  logic                   rst_n;
  logic                   in_valid;
  logic                   in_ready;
  logic [N-1:0]           in_a;
  logic [N-1:0]           in_b;
  logic [TAG_W-1:0]       in_tag;
  logic                   out_valid;
  logic                   out_ready;
  logic [2*N-1:0]         out_c;
  logic [TAG_W-1:0]       out_tag;
  logic                   out_err;
  logic                   mul_load;
  logic [N-1:0]           mul_a;
  logic [N-1:0]           mul_b;
  logic                   mul_done;
  logic [2*N-1:0]         mul_c;
  logic [$clog2(DEPTH):0] fifo_count;
  logic [7:0]             err_count;

  booth_mult_scheduler #(
    .N(N), .DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_c(out_c), .out_tag(out_tag), .out_err(out_err),
    .mul_load(mul_load), .mul_a(mul_a), .mul_b(mul_b),
    .mul_done(mul_done), .mul_c(mul_c),
    .fifo_count(fifo_count), .err_count(err_count)
  );

  typedef struct {
    logic [N-1:0]     a;
    logic [N-1:0]     b;
    logic [TAG_W-1:0] tag;
  } job_t;

  typedef struct {
    logic [2*N-1:0]   c;
    logic [TAG_W-1:0] tag;
    logic             err;
    logic [N-1:0]     a;
    logic [N-1:0]     b;
  } res_t;

  job_t ld_q[$];
  res_t res_q[$];

  int tests_run    = 0;
  int tests_failed = 0;
  int hang_jobs    = 0;
  int core_cnt     = 0;
  int loads        = 0;
  int exp_errs     = 0;
  int cyc          = 0;
  int ld_cyc       = 0;
  logic [2*N-1:0] core_prod;
  logic prev_ov = 1'b0;
  logic prev_ml = 1'b0;
  logic push5_done;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] sprod(input logic [N-1:0] a, input logic [N-1:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return sa * sb;
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [N-1:0] a, input logic [N-1:0] b, input logic [TAG_W-1:0] tag);
    int   waitc;
    job_t j;
    waitc    = 0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
    while (!in_ready && waitc < 500) begin
      tick();
      waitc++;
    end
    check("push_accept", in_ready, 1);
    if (in_ready) begin
      j.a = a; j.b = b; j.tag = tag;
      ld_q.push_back(j);
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_out_valid();
    int waitc;
    waitc = 0;
    while (!out_valid && waitc < 500) begin
      tick();
      waitc++;
    end
    check("wait_out_valid", out_valid, 1);
  endtask

  task automatic wait_drain();
    int waitc;
    waitc = 0;
    while ((ld_q.size() != 0 || res_q.size() != 0 || out_valid) && waitc < 3000) begin
      tick();
      waitc++;
    end
    check("drain", (ld_q.size() == 0) && (res_q.size() == 0), 1);
  endtask

  // Behavioural core plus scoreboard: observes loads and result handshakes mid-cycle.
  initial begin
    mul_done = 1'b0;
    mul_c    = '0;
    forever begin
      @(negedge clk);
      mul_done = 1'b0;
      if (!rst_n) begin
        core_cnt = 0;
        prev_ov  = 1'b0;
        prev_ml  = 1'b0;
      end else begin
        if (core_cnt != 0) begin
          core_cnt--;
          if (core_cnt == 0) begin
            mul_done = 1'b1;
            mul_c    = core_prod;
          end
        end
        if (mul_load) begin
          job_t j;
          res_t r;
          loads++;
          ld_cyc = cyc;
          check("load_single_cycle", prev_ml, 0);
          check("load_expected", ld_q.size() != 0, 1);
          if (ld_q.size() != 0) begin
            j = ld_q.pop_front();
            check("mul_a", mul_a, j.a);
            check("mul_b", mul_b, j.b);
            r.tag = j.tag;
            r.a   = j.a;
            r.b   = j.b;
            if (hang_jobs > 0) begin
              hang_jobs--;
              r.err = 1'b1;
              r.c   = '0;
            end else begin
              r.err     = 1'b0;
              r.c       = sprod(j.a, j.b);
              core_prod = sprod(mul_a, mul_b);
              core_cnt  = $urandom_range(1, 8);
            end
            res_q.push_back(r);
          end
        end
        if (out_valid && !prev_ov && res_q.size() != 0 && res_q[0].err)
          check("timeout_latency", cyc - ld_cyc, TIMEOUT + 1);
        if (out_valid && out_ready) begin
          res_t r;
          check("result_expected", res_q.size() != 0, 1);
          if (res_q.size() != 0) begin
            r = res_q.pop_front();
            if (r.err && exp_errs < 255) exp_errs++;
            check("out_c", out_c, r.c);
            check("out_tag", out_tag, r.tag);
            check("out_err", out_err, r.err);
            check("err_count", err_count, exp_errs);
            check("mul_a_hold", mul_a, r.a);
            check("mul_b_hold", mul_b, r.b);
          end
        end
        prev_ov = out_valid;
        prev_ml = mul_load;
      end
    end
  end

  initial begin
    logic [N-1:0] a0, b0;
    int           l0;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_tag    = '0;
    out_ready = 1'b1;
    repeat (3) tick();
    check("rst_in_ready", in_ready, 1);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_mul_load", mul_load, 0);
    check("rst_mul_a", mul_a, 0);
    check("rst_out_c", out_c, 0);
    check("rst_err_count", err_count, 0);
    rst_n = 1'b1;
    tick();

    // Single job
    l0 = loads;
    push(32'd3, 32'hFFFF_FFFB, 4'd2);
    wait_drain();
    check("single_loads", loads - l0, 1);

    // Fill, ordering and backpressure
    out_ready = 1'b0;
    a0 = $urandom();
    b0 = $urandom();
    push(a0, b0, 4'd0);
    for (int t = 1; t < 5; t++) push($urandom(), $urandom(), TAG_W'(t));
    check("fill_count", fifo_count, 4);
    check("fill_in_ready", in_ready, 0);
    push5_done = 1'b0;
    fork
      begin
        push($urandom(), $urandom(), 4'd5);
        push5_done = 1'b1;
      end
    join_none
    wait_out_valid();
    l0 = loads;
    for (int k = 0; k < 20; k++) begin
      tick();
      check("bp_out_c", out_c, sprod(a0, b0));
      check("bp_out_tag", out_tag, 0);
      check("bp_out_err", out_err, 0);
      check("bp_fifo_count", fifo_count, 4);
    end
    check("bp_no_load", loads - l0, 0);
    out_ready = 1'b1;
    for (int k = 0; k < 200 && !push5_done; k++) tick();
    check("push5_done", push5_done, 1);
    wait_drain();

    // Timeout, then a normal job
    hang_jobs = 1;
    push($urandom(), $urandom(), 4'd7);
    push($urandom(), $urandom(), 4'd8);
    wait_drain();
    check("timeout_err_count", err_count, 1);

    // Corner operands
    push(32'h8000_0000, 32'h8000_0000, 4'd9);
    push(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd10);
    push(32'h0000_0000, 32'h7FFF_FFFF, 4'd11);
    wait_drain();

    // Random traffic with random backpressure
    fork
      begin
        for (int k = 0; k < 20; k++) begin
          repeat ($urandom_range(0, 3)) tick();
          push($urandom(), $urandom(), TAG_W'($urandom_range(0, 15)));
        end
      end
      begin
        repeat (400) begin
          out_ready = 1'($urandom_range(0, 1));
          tick();
        end
        out_ready = 1'b1;
      end
    join
    wait_drain();

    // Reset during WAIT with two queued jobs
    hang_jobs = 1;
    push($urandom(), $urandom(), 4'd12);
    push($urandom(), $urandom(), 4'd13);
    push($urandom(), $urandom(), 4'd14);
    repeat (10) tick();
    check("pre_rst_count", fifo_count, 2);
    rst_n = 1'b0;
    #1;
    check("mid_rst_fifo_count", fifo_count, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_mul_load", mul_load, 0);
    check("mid_rst_mul_a", mul_a, 0);
    check("mid_rst_mul_b", mul_b, 0);
    check("mid_rst_out_c", out_c, 0);
    check("mid_rst_out_tag", out_tag, 0);
    check("mid_rst_out_err", out_err, 0);
    check("mid_rst_err_count", err_count, 0);
    ld_q.delete();
    res_q.delete();
    hang_jobs = 0;
    exp_errs  = 0;
    repeat (3) tick();
    rst_n = 1'b1;
    l0 = loads;
    repeat (30) tick();
    check("post_rst_no_load", loads - l0, 0);
    check("post_rst_out_valid", out_valid, 0);
    check("post_rst_fifo_count", fifo_count, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
